// File: rtl/debug_stepper.sv
// ---------------------------------------------------------------------------
// debug_stepper
//   Single-step / burst-run controller for a debug-attached processor core.
//   Operator requests (asynchronous) are synchronized and turned into
//   one-cycle cpu_clk_en pulses. The processor status that follows each pulse
//   is snapshotted. An exception flag parks the block in TRAP until the
//   operator issues a processor reset.
//
// Ports
//   clk, reset          : clock and synchronous active-high block reset
//   step_req            : single step (rising edge)
//   run_req, halt_req   : continuous run while run_req=1 and halt_req=0 (levels)
//   rst_req             : processor reset request (rising edge), highest priority
//   ovr_req             : arm the interrupt override for the next step (rising edge)
//   run_limit[15:0]     : steps per run burst, 0 = unlimited
//   pcactual/x31/idata  : processor status, valid the cycle after cpu_clk_en
//   invalid..branch_fail: processor exception flags, sampled with the status
//   cpu_clk_en          : one-cycle step enable to the processor
//   cpu_reset           : processor reset, 4 cycles long
//   override            : interrupt override, coincident with one cpu_clk_en
//   snap_pc/x31/idata   : status captured after the last step
//   trap_cause[4:0]     : {invalid,readerror,writeerror,outofbound,branch_fail}
//   step_count[31:0]    : steps issued since the last reset (wraps)
//   state[2:0]          : IDLE=0 PULSE=1 CAPTURE=2 TRAP=3 CPURST=4
// ---------------------------------------------------------------------------
module debug_stepper (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_req,
   input  logic        run_req,
   input  logic        halt_req,
   input  logic        rst_req,
   input  logic        ovr_req,
   input  logic [15:0] run_limit,
   input  logic [31:0] pcactual,
   input  logic [31:0] x31,
   input  logic [31:0] idata,
   input  logic        invalid,
   input  logic        readerror,
   input  logic        writeerror,
   input  logic        outofboundaccess,
   input  logic        branch_fail,
   output logic        cpu_clk_en,
   output logic        cpu_reset,
   output logic        override,
   output logic [31:0] snap_pc,
   output logic [31:0] snap_x31,
   output logic [31:0] snap_idata,
   output logic [4:0]  trap_cause,
   output logic [31:0] step_count,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PULSE   = 3'd1,
      CAPTURE = 3'd2,
      TRAP    = 3'd3,
      CPURST  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // request bit order inside the synchronizer: {ovr, rst, halt, run, step}
   logic [4:0]  w_req_raw;
   logic [4:0]  r_sync1;
   logic [4:0]  r_sync2;
   logic [2:0]  r_prev;          // {ovr, rst, step} delayed for edge detect

   logic        w_step_edge;
   logic        w_rst_edge;
   logic        w_ovr_edge;
   logic        w_run;
   logic        w_halt;
   logic        w_run_ok;
   logic        w_run_cont;

   logic [4:0]  w_flags;
   logic        w_trap;

   logic [15:0] r_burst;
   logic [1:0]  r_rst_cnt;
   logic        r_ovr_pend;
   logic        r_run_done;

   logic [31:0] r_step_count;
   logic [31:0] w_step_count_nxt;
   logic [31:0] r_snap_pc;
   logic [31:0] r_snap_x31;
   logic [31:0] r_snap_idata;
   logic [4:0]  r_trap_cause;

   // ------------------------------------------------------------------
   // Request synchronizers and edge detectors
   // ------------------------------------------------------------------
   assign w_req_raw = {ovr_req, rst_req, halt_req, run_req, step_req};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= w_req_raw;
         r_sync2 <= r_sync1;
         r_prev  <= {r_sync2[4], r_sync2[3], r_sync2[0]};
      end
   end

   assign w_step_edge = r_sync2[0] & ~r_prev[0];
   assign w_rst_edge  = r_sync2[3] & ~r_prev[1];
   assign w_ovr_edge  = r_sync2[4] & ~r_prev[2];
   assign w_run       = r_sync2[1];
   assign w_halt      = r_sync2[2];
   assign w_run_ok    = w_run & ~w_halt;

   // burst continues while below the limit; a zero limit never stops it
   assign w_run_cont  = w_run_ok & ((run_limit == 16'd0) | (r_burst < run_limit));

   assign w_flags = {invalid, readerror, writeerror, outofboundaccess, branch_fail};
   assign w_trap  = |w_flags;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM: next state. A rst edge beats everything, including TRAP.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      if (w_rst_edge) begin
         w_state_nxt = CPURST;
      end else begin
         unique case (r_state)
            IDLE: begin
               // r_run_done keeps a finished bounded burst from restarting
               // while run_req is still held high
               if (w_step_edge || (w_run_ok && !r_run_done))
                  w_state_nxt = PULSE;
            end
            PULSE:   w_state_nxt = CAPTURE;
            CAPTURE: begin
               if (w_trap)          w_state_nxt = TRAP;
               else if (w_run_cont) w_state_nxt = PULSE;
               else                 w_state_nxt = IDLE;
            end
            TRAP:    w_state_nxt = TRAP;
            CPURST:  if (r_rst_cnt == 2'd3) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      cpu_clk_en = 1'b0;
      cpu_reset  = 1'b0;
      override   = 1'b0;
      unique case (r_state)
         PULSE: begin
            cpu_clk_en = 1'b1;
            override   = r_ovr_pend;
         end
         CPURST:  cpu_reset = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   // step_count is rewritten every cycle (hold included) so a value placed
   // into the register from outside is carried forward normally.
   always_comb begin
      w_step_count_nxt = r_step_count;
      if (w_rst_edge)             w_step_count_nxt = '0;
      else if (r_state == PULSE)  w_step_count_nxt = r_step_count + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_step_count <= '0;
         r_burst      <= '0;
         r_rst_cnt    <= '0;
         r_ovr_pend   <= 1'b0;
         r_run_done   <= 1'b0;
         r_snap_pc    <= '0;
         r_snap_x31   <= '0;
         r_snap_idata <= '0;
         r_trap_cause <= '0;
      end else begin
         r_step_count <= w_step_count_nxt;

         if (r_state == IDLE && w_state_nxt == PULSE) r_burst <= '0;
         else if (r_state == PULSE)                   r_burst <= r_burst + 16'd1;

         // counts cycles spent in CPURST; restarts on a repeated rst edge
         if (r_state == CPURST && !w_rst_edge) r_rst_cnt <= r_rst_cnt + 2'd1;
         else                                  r_rst_cnt <= '0;

         // one armed override at most; consumed by the pulse it rides on
         if (w_rst_edge)                        r_ovr_pend <= 1'b0;
         else if (r_state == PULSE && r_ovr_pend) r_ovr_pend <= 1'b0;
         else if (w_ovr_edge)                   r_ovr_pend <= 1'b1;

         if (!w_run)
            r_run_done <= 1'b0;
         else if (r_state == CAPTURE && w_state_nxt == IDLE && w_run_ok)
            r_run_done <= 1'b1;

         if (w_rst_edge) begin
            r_snap_pc    <= '0;
            r_snap_x31   <= '0;
            r_snap_idata <= '0;
            r_trap_cause <= '0;
         end else if (r_state == CAPTURE) begin
            r_snap_pc    <= pcactual;
            r_snap_x31   <= x31;
            r_snap_idata <= idata;
            if (w_trap) r_trap_cause <= w_flags;
         end
      end
   end

   assign snap_pc    = r_snap_pc;
   assign snap_x31   = r_snap_x31;
   assign snap_idata = r_snap_idata;
   assign trap_cause = r_trap_cause;
   assign step_count = r_step_count;
   assign state      = r_state;

endmodule

// File: doc/debug_stepper.md
DEBUG_STEPPER -- requirements
Module: debug_stepper

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 clk  input  1  system clock; every flop in the block is clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high block reset.
REQ-004 step_req, run_req, halt_req, rst_req, ovr_req  input  1 each  asynchronous operator controls.
REQ-005 run_limit  input  16  maximum steps per run burst; 0 means unlimited.
REQ-006 pcactual, x31, idata  input  32 each  processor status, valid the cycle after cpu_clk_en.
REQ-007 invalid, readerror, writeerror, outofboundaccess, branch_fail  input  1 each  processor exception flags.
REQ-008 cpu_clk_en  output  1  one-cycle enable; each pulse advances the processor one step.
REQ-009 cpu_reset  output  1  processor reset.
REQ-010 override  output  1  processor interrupt override.
REQ-011 snap_pc, snap_x31, snap_idata  output  32 each  status captured after the last step.
REQ-012 trap_cause  output  5  {invalid, readerror, writeerror, outofboundaccess, branch_fail} latched at trap entry.
REQ-013 step_count  output  32  steps issued since the last reset.
REQ-014 state  output  3  FSM state encoding: IDLE=0, PULSE=1, CAPTURE=2, TRAP=3, CPURST=4.

Function
REQ-015 Each of the five operator inputs SHALL pass through a 2-flop synchronizer; the FSM uses only the synchronized versions.
REQ-016 Edge detection on step, rst and ovr SHALL be synchronized-high with prior-low; an input first sampled high at edge k acts at edge k+2.
REQ-017 IDLE: on a step edge, or on synchronized run_req high with halt_req low, go to PULSE and clear the burst counter.
REQ-018 PULSE SHALL last exactly one cycle: cpu_clk_en=1, step_count+1 (wraps 0xFFFFFFFF->0), burst counter+1, then go to CAPTURE.
REQ-019 CAPTURE SHALL last one cycle: latch all three snap_* registers and OR the five exception flags.
REQ-020 CAPTURE exit, in priority order: any flag set -> TRAP with trap_cause latched; else run continues (run_req high, halt_req low, run_limit 0 or burst < run_limit) -> PULSE; else -> IDLE.
REQ-021 Continuous run SHALL therefore pulse cpu_clk_en exactly every 2 cycles.
REQ-022 TRAP SHALL hold with cpu_clk_en=0; step and run requests are ignored; the only exit is a rst edge.
REQ-023 A rst edge in any state SHALL win over all other events: go to CPURST, clear step_count, trap_cause, snap_* and pending override.
REQ-024 CPURST SHALL hold cpu_reset=1 for exactly 4 cycles, then go to IDLE.
REQ-025 An ovr edge SHALL set a pending flag; override SHALL be asserted in the same cycle as the next cpu_clk_en pulse, and the flag SHALL then clear.
REQ-026 Further ovr edges while the flag is pending SHALL not queue.
REQ-027 A step edge arriving outside IDLE SHALL be dropped, not queued.

Reset
REQ-028 reset SHALL return the block to IDLE and drive all outputs to 0 on the next clk edge, including cpu_reset, with the burst counter, pending flag and synchronizers cleared.
REQ-029 reset SHALL take priority over every other input, including reset asserted mid-PULSE or mid-CPURST.

Verification
REQ-030 Single step: step_req rises and pcactual=0x4 -> one cpu_clk_en pulse 3 cycles later, snap_pc=0x4, step_count=1, state back to IDLE.
REQ-031 Bounded run: run_limit=5, run_req held high -> exactly 5 cpu_clk_en pulses spaced 2 cycles apart, then IDLE, step_count=5.
REQ-032 Trap: during a run, readerror=1 after pulse 3 -> TRAP, trap_cause=5'b01000, no further pulses; then a rst_req edge -> cpu_reset high 4 cycles, IDLE, step_count=0.
REQ-033 Override: ovr_req pulsed twice while IDLE, then step_req -> override high only with that cpu_clk_en pulse, low on the next step.
REQ-034 Reset mid-run: reset asserted during PULSE -> on the next edge cpu_clk_en=0, state=0, step_count=0; step_count wrap from 0xFFFFFFFF -> 0 is checked by forced preload.
